// File: rtl/res_tx.sv
// Result transmitter: pops 16-bit results from the result FIFO and streams each
// as two bytes (MSB first) over a byte-wide valid/ready link, one frame per start.
module res_tx #(
  parameter int NUM_RESULTS = 1352,
  parameter int CNT_W       = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             fifo_empty,
  input  logic [15:0]      fifo_data,
  output logic             fifo_renable,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] res_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_SEND_HI = 3'd2;
  localparam logic [2:0] S_SEND_LO = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // Counter value while the final result of the frame is in SEND_LO.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_RESULTS - 1);

  logic [2:0]       state_q, state_d;
  logic [15:0]      hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop_s;

  assign pop_s = (state_q == S_FETCH) && !fifo_empty;

  // Next-state, hold-register and result-counter logic.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (pop_s) begin
          hold_d  = fifo_data;
          state_d = S_SEND_HI;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_SEND_HI: begin
        if (tx_ready) begin
          state_d = S_SEND_LO;
        end else begin
          state_d = S_SEND_HI;
        end
      end
      S_SEND_LO: begin
        if (tx_ready) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_SEND_LO;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, hold and counter registers; reset discards any held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hold_q  <= 16'd0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from the state register, so they are all zero in reset.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'd0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_FETCH: begin
        busy = 1'b1;
      end
      S_SEND_HI: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = hold_q[15:8];
      end
      S_SEND_LO: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = hold_q[7:0];
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign fifo_renable = pop_s;
  assign res_count    = cnt_q;

endmodule

// File: tb/tb_res_tx.sv
// Directed bench for res_tx: a 3-result instance for protocol cases and a
// full-size instance for the 1352-result frame, each fed by a simple FIFO model.
module tb_res_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- instance A: NUM_RESULTS = 3 ----------------
  logic        a_start = 1'b0, a_rdy = 1'b0;
  logic        a_empty, a_ren, a_txv, a_busy, a_done;
  logic [15:0] a_data;
  logic [7:0]  a_txd;
  logic [10:0] a_cnt;
  logic [15:0] a_mem [0:63];
  int          a_wr = 0, a_rd = 0;

  assign a_empty = (a_rd == a_wr);
  assign a_data  = a_empty ? 16'hDEAD : a_mem[a_rd];

  res_tx #(.NUM_RESULTS(3), .CNT_W(11)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .fifo_empty(a_empty), .fifo_data(a_data),
    .fifo_renable(a_ren), .tx_data(a_txd), .tx_valid(a_txv), .tx_ready(a_rdy),
    .busy(a_busy), .done(a_done), .res_count(a_cnt)
  );

  // ---------------- instance B: full-size frame ----------------
  logic        b_start = 1'b0, b_rdy = 1'b0;
  logic        b_empty, b_ren, b_txv, b_busy, b_done;
  logic [15:0] b_data;
  logic [7:0]  b_txd;
  logic [10:0] b_cnt;
  logic [15:0] b_mem [0:2047];
  int          b_wr = 0, b_rd = 0;

  assign b_empty = (b_rd == b_wr);
  assign b_data  = b_empty ? 16'hDEAD : b_mem[b_rd];

  res_tx dut_b (
    .clk(clk), .rst(rst), .start(b_start), .fifo_empty(b_empty), .fifo_data(b_data),
    .fifo_renable(b_ren), .tx_data(b_txd), .tx_valid(b_txv), .tx_ready(b_rdy),
    .busy(b_busy), .done(b_done), .res_count(b_cnt)
  );

  // ---------------- monitors ----------------
  int       cyc = 0;
  logic [7:0] a_bytes [0:255];
  logic [7:0] b_bytes [0:4095];
  int a_nb = 0, a_pops = 0, a_ndone = 0, a_last_hs = 0, a_done_cyc = 0, a_stab = 0;
  int b_nb = 0, b_pops = 0, b_ndone = 0, b_stab = 0;
  logic       a_hold_v = 1'b0, b_hold_v = 1'b0;
  logic [7:0] a_hold_d = 8'd0, b_hold_d = 8'd0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_ren && !a_empty) begin
      a_rd   <= a_rd + 1;
      a_pops <= a_pops + 1;
    end
    if (a_txv && a_rdy) begin
      a_bytes[a_nb] <= a_txd;
      a_nb          <= a_nb + 1;
      a_last_hs     <= cyc;
    end
    if (a_done) begin
      a_ndone    <= a_ndone + 1;
      a_done_cyc <= cyc;
    end
    if (!rst && ((a_hold_v && !(a_txv && a_txd == a_hold_d)) ||
                 (!a_txv && a_txd != 8'd0) || (a_ren && !a_busy)))
      a_stab <= a_stab + 1;
    a_hold_v <= !rst && a_txv && !a_rdy;
    a_hold_d <= a_txd;
  end

  always @(posedge clk) begin
    if (b_ren && !b_empty) begin
      b_rd   <= b_rd + 1;
      b_pops <= b_pops + 1;
    end
    if (b_txv && b_rdy) begin
      b_bytes[b_nb] <= b_txd;
      b_nb          <= b_nb + 1;
    end
    if (b_done) b_ndone <= b_ndone + 1;
    if (!rst && ((b_hold_v && !(b_txv && b_txd == b_hold_d)) ||
                 (!b_txv && b_txd != 8'd0) || (b_ren && !b_busy)))
      b_stab <= b_stab + 1;
    b_hold_v <= !rst && b_txv && !b_rdy;
    b_hold_d <= b_txd;
  end

  // ---------------- helpers ----------------
  task automatic push_a(input logic [15:0] v);
    a_mem[a_wr] = v;
    a_wr++;
  endtask

  task automatic pulse_start_a();
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int budget);
    int k = 0;
    while (!a_done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, {31'd0, a_done}, 32'd1);
  endtask

  task automatic check_bytes_a(input string tag, input int base, input logic [47:0] exp);
    logic [47:0] got;
    got = 48'd0;
    for (int i = 0; i < 6; i++) got = {got[39:0], a_bytes[base + i]};
    check_val({tag, "_nbytes"}, a_nb - base, 32'd6);
    check_val({tag, "_hi32"}, got[47:16], exp[47:16]);
    check_val({tag, "_lo16"}, {16'd0, got[15:0]}, {16'd0, exp[15:0]});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nb0, p0, d0, bad;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_outs_a", {9'd0, a_ren, a_txv, a_txd, a_busy, a_done, a_cnt}, 32'd0);
    check_val("rst_outs_b", {9'd0, b_ren, b_txv, b_txd, b_busy, b_done, b_cnt}, 32'd0);
    rst = 1'b0;

    // 1: start with an empty FIFO
    pulse_start_a();
    check_val("t1_busy", {31'd0, a_busy}, 32'd1);
    repeat (3) @(negedge clk);
    check_val("t1_idle_io", {30'd0, a_ren, a_txv}, 32'd0);

    // 2: three results streamed with tx_ready high
    nb0 = a_nb; p0 = a_pops; d0 = a_ndone;
    a_rdy = 1'b1;
    push_a(16'd68); push_a(16'd2021); push_a(16'd984);
    wait_done_a("t2_done", 100);
    a_start = 1'b1;                 // lands on the DONE cycle and must be ignored
    @(negedge clk) a_start = 1'b0;
    @(negedge clk);
    check_val("t2_start_in_done", {31'd0, a_busy}, 32'd0);
    check_bytes_a("t2", nb0, 48'h0044_07E5_03D8);
    check_val("t2_pops", a_pops - p0, 32'd3);
    check_val("t2_ndone", a_ndone - d0, 32'd1);
    check_val("t2_done_lat", a_done_cyc - a_last_hs, 32'd1);
    check_val("t2_cnt", {21'd0, a_cnt}, 32'd3);

    // 3: backpressure on both bytes
    nb0 = a_nb; p0 = a_pops;
    push_a(16'hABCD); push_a(16'h0001); push_a(16'h0002);
    a_rdy = 1'b0;
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
    check_val("t3_start_lat", {31'd0, a_ren}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("t3_hi_hold", {23'd0, a_txv, a_txd}, {23'd0, 1'b1, 8'hAB});
    end
    a_rdy = 1'b1;
    @(negedge clk) a_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_val("t3_lo_hold", {23'd0, a_txv, a_txd}, {23'd0, 1'b1, 8'hCD});
      @(negedge clk);
    end
    check_val("t3_pops_stall", a_pops - p0, 32'd1);
    a_rdy = 1'b1;
    wait_done_a("t3_done", 100);
    check_bytes_a("t3", nb0, 48'hABCD_0001_0002);
    check_val("t3_pops", a_pops - p0, 32'd3);

    // 4: FIFO runs dry mid-frame
    @(negedge clk);
    nb0 = a_nb;
    push_a(16'h1111);
    pulse_start_a();
    repeat (6) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (a_ren || !a_busy || a_txv) bad++;
      @(negedge clk);
    end
    check_val("t4_wait_fetch", bad, 32'd0);
    check_val("t4_cnt_mid", {21'd0, a_cnt}, 32'd1);
    push_a(16'h1234); push_a(16'h5678);
    wait_done_a("t4_done", 100);
    check_bytes_a("t4", nb0, 48'h1111_1234_5678);
    check_val("t4_cnt", {21'd0, a_cnt}, 32'd3);

    // 5: full 1352-result frame, with a start pulse while busy
    for (int i = 1; i <= 1352; i++) begin
      b_mem[b_wr] = 16'(i);
      b_wr++;
    end
    b_rdy = 1'b1;
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    repeat (100) @(negedge clk);
    b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    begin
      int k = 0;
      while (!b_done && k < 6000) begin
        @(negedge clk);
        k++;
      end
    end
    check_val("t5_done", {31'd0, b_done}, 32'd1);
    check_val("t5_nbytes", b_nb, 32'd2704);
    bad = 0;
    for (int i = 0; i < 1352; i++)
      if ({b_bytes[2*i], b_bytes[2*i+1]} != 16'(i + 1)) bad++;
    check_val("t5_pairs", bad, 32'd0);
    check_val("t5_cnt", {21'd0, b_cnt}, 32'd1352);
    check_val("t5_pops", b_pops, 32'd1352);
    repeat (3) @(negedge clk);
    check_val("t5_ndone", b_ndone, 32'd1);
    check_val("t5_idle", {31'd0, b_busy}, 32'd0);

    // 6: reset while the 0x5555 low byte is pending
    push_a(16'h0102); push_a(16'h5555);
    push_a(16'h0304); push_a(16'h0506); push_a(16'h0708);
    a_rdy = 1'b1;
    pulse_start_a();
    begin
      int k = 0;
      while (!(a_cnt == 11'd1 && a_txv) && k < 50) begin
        @(negedge clk);
        k++;
      end
    end
    @(negedge clk) a_rdy = 1'b0;
    check_val("t6_pre", {12'd0, a_txv, a_txd, a_cnt}, {12'd0, 1'b1, 8'h55, 11'd1});
    rst = 1'b1;
    #1;
    check_val("t6_rst", {11'd0, a_txv, a_busy, a_ren, a_txd, a_cnt}, 32'd0);
    @(negedge clk) rst = 1'b0;
    nb0 = a_nb;
    a_rdy = 1'b1;
    pulse_start_a();
    wait_done_a("t6_done", 100);
    check_bytes_a("t6", nb0, 48'h0304_0506_0708);
    check_val("t6_cnt", {21'd0, a_cnt}, 32'd3);

    // Stream-protocol violations seen by the monitors
    check_val("stream_rules_a", a_stab, 32'd0);
    check_val("stream_rules_b", b_stab, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
